// File: rtl/edge_trace_pkg.sv
`default_nettype none
// ============================================================================
// Module   : edge_trace_pkg
// Summary  : Shared types for the edge trace capture block. The event ts
//            field exists only when EDGE_TRACE_TIMESTAMP_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
package edge_trace_pkg;

  localparam int DROP_CNT_W = 8;
  // Event fields are sized for the largest supported configuration
  // (NUM_CH <= 256, TS_W <= 32); unused upper bits are constant zero.
  localparam int EVT_CH_W   = 8;
  localparam int EVT_TS_W   = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    FLUSH   = 2'd2
  } state_e;

  typedef struct packed {
    logic [EVT_CH_W-1:0] ch;
    logic                level;
`ifdef EDGE_TRACE_TIMESTAMP_EN
    logic [EVT_TS_W-1:0] ts;
`endif
  } evt_t;

endpackage
`default_nettype wire

// File: rtl/edge_trace_fifo.sv
`default_nettype none
// ============================================================================
// Module   : edge_trace_fifo
// Summary  : Synchronous first-word-fall-through event FIFO, DEPTH entries.
// Revision : 1.0 - initial release
// ============================================================================
module edge_trace_fifo
  import edge_trace_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  logic pop,
  input  evt_t din,
  output evt_t dout,
  output logic full,
  output logic empty
);

  localparam int              PTR_W    = $clog2(DEPTH);
  localparam logic [PTR_W:0]  FULL_CNT = (PTR_W + 1)'(DEPTH);

  evt_t             mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             do_push, do_pop;

  // A push into a full FIFO is accepted when the head leaves on the same edge.
  always_comb begin
    do_pop   = pop && (count_q != '0);
    do_push  = push && ((count_q != FULL_CNT) || do_pop);
    wr_ptr_d = do_push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + (PTR_W + 1)'(1);
    end else if (do_pop && !do_push) begin
      count_d = count_q - (PTR_W + 1)'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

  assign dout  = mem_q[rd_ptr_q];
  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);

endmodule
`default_nettype wire

// File: rtl/edge_trace_capture.sv
`default_nettype none
// ============================================================================
// Module   : edge_trace_capture
// Summary  : Per-line edge detector feeding an event FIFO; lowest pending
//            channel wins. Timestamps enabled by EDGE_TRACE_TIMESTAMP_EN.
// Revision : 1.0 - initial release
// ============================================================================
module edge_trace_capture
  import edge_trace_pkg::*;
#(
  parameter int NUM_CH = 20,
  parameter int DEPTH  = 16,
  parameter int TS_W   = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      enable,
  input  logic [NUM_CH-1:0]         sig_i,
  output logic                      evt_valid,
  input  logic                      evt_ready,
  output logic [$clog2(NUM_CH)-1:0] evt_ch,
  output logic                      evt_level,
  output logic [TS_W-1:0]           evt_ts,
  output logic                      overflow,
  output logic [DROP_CNT_W-1:0]     drop_cnt
);

  localparam int CH_W = $clog2(NUM_CH);

  state_e                state_q, state_d;
  logic [NUM_CH-1:0]     sig_q, sig_d;
  logic [NUM_CH-1:0]     pending_q, pending_d;
  logic                  overflow_q, overflow_d;
  logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic [NUM_CH-1:0]     change, sel_oh, push_oh, drop;
  logic [CH_W-1:0]       sel_idx;
  logic                  sel_found, sel_level;
  logic                  push_en, pop_en, fifo_full, fifo_empty;
  evt_t                  push_evt, head_evt;
  logic                  unused_head_bits;
`ifdef EDGE_TRACE_TIMESTAMP_EN
  logic [TS_W-1:0]       ts_cnt_q, ts_cnt_d;
`endif

  always_comb begin
    sel_oh    = '0;
    sel_idx   = '0;
    sel_found = 1'b0;
    sel_level = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (pending_q[i] && !sel_found) begin
        sel_found = 1'b1;
        sel_oh[i] = 1'b1;
        sel_idx   = CH_W'(i);
        sel_level = sig_q[i];
      end
    end
  end

  assign pop_en  = !fifo_empty && evt_ready;
  assign push_en = sel_found && (!fifo_full || pop_en);
  assign push_oh = push_en ? sel_oh : '0;

  // A change on the channel being pushed re-arms it rather than counting as loss.
  always_comb begin
    sig_d      = sig_i;
    change     = (state_q == CAPTURE) ? (sig_i ^ sig_q) : '0;
    drop       = change & pending_q & ~push_oh;
    pending_d  = (pending_q & ~push_oh) | change;
    overflow_d = overflow_q | (|drop);
    drop_cnt_d = drop_cnt_q;
    for (int i = 0; i < NUM_CH; i++) begin
      if (drop[i] && (drop_cnt_d != {DROP_CNT_W{1'b1}})) begin
        drop_cnt_d = drop_cnt_d + DROP_CNT_W'(1);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (enable) state_d = CAPTURE;
      end
      CAPTURE: begin
        if (!enable) state_d = (|pending_q) ? FLUSH : IDLE;
      end
      FLUSH: begin
        if (enable) begin
          state_d = CAPTURE;
        end else if (!(|pending_q)) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    push_evt       = '0;
    push_evt.ch    = EVT_CH_W'(sel_idx);
    push_evt.level = sel_level;
`ifdef EDGE_TRACE_TIMESTAMP_EN
    push_evt.ts    = EVT_TS_W'(ts_cnt_q);
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      sig_q      <= '0;
      pending_q  <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      sig_q      <= sig_d;
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

`ifdef EDGE_TRACE_TIMESTAMP_EN
  always_comb begin
    ts_cnt_d = ts_cnt_q + TS_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts_cnt_q <= '0;
    end else begin
      ts_cnt_q <= ts_cnt_d;
    end
  end
`endif

  edge_trace_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_en),
    .pop   (pop_en),
    .din   (push_evt),
    .dout  (head_evt),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Head fields are forced to zero while empty so stale storage never shows.
  assign evt_valid        = !fifo_empty;
  assign evt_ch           = evt_valid ? head_evt.ch[CH_W-1:0] : '0;
  assign evt_level        = evt_valid & head_evt.level;
  assign unused_head_bits = ^head_evt;
`ifdef EDGE_TRACE_TIMESTAMP_EN
  assign evt_ts           = evt_valid ? head_evt.ts[TS_W-1:0] : '0;
`else
  assign evt_ts           = '0;
`endif
  assign overflow         = overflow_q;
  assign drop_cnt         = drop_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_edge_trace_capture.sv
`default_nettype none
// ============================================================================
// Module   : tb_edge_trace_capture
// Summary  : Self-checking bench for edge_trace_capture with an event-queue
//            reference model. Honours EDGE_TRACE_TIMESTAMP_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_edge_trace_capture;

  localparam int NUM_CH = 20;
  localparam int DEPTH  = 16;
  localparam int TS_W   = 16;
  localparam int M_IDLE = 0;
  localparam int M_CAP  = 1;
  localparam int M_FLSH = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              enable = 1'b0;
  logic              evt_ready = 1'b0;
  logic [NUM_CH-1:0] sig_i = '0;
  logic              evt_valid;
  logic [4:0]        evt_ch;
  logic              evt_level;
  logic [TS_W-1:0]   evt_ts;
  logic              overflow;
  logic [7:0]        drop_cnt;

  int checks = 0;
  int errors = 0;

  edge_trace_capture #(
    .NUM_CH (NUM_CH),
    .DEPTH  (DEPTH),
    .TS_W   (TS_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .sig_i     (sig_i),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_ch    (evt_ch),
    .evt_level (evt_level),
    .evt_ts    (evt_ts),
    .overflow  (overflow),
    .drop_cnt  (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] ts_exp(input int v);
`ifdef EDGE_TRACE_TIMESTAMP_EN
    return 64'(v);
`else
    return 64'(v - v);
`endif
  endfunction

  // Reference model: a queue of events plus the pending set and counters.
  typedef struct {
    int ch;
    int lvl;
    int ts;
  } mev_t;

  mev_t              mq[$];
  mev_t              mev;
  bit [NUM_CH-1:0]   mpend, mprev;
  int                mstate, mts, mdrop, msel;
  bit                movf, mpop, many;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      mpend  = '0;
      mprev  = '0;
      mstate = M_IDLE;
      mts    = 0;
      mdrop  = 0;
      movf   = 1'b0;
    end else begin
      many = (mpend != '0);
      mpop = (mq.size() > 0) && evt_ready;
      msel = -1;
      for (int i = 0; i < NUM_CH; i++) begin
        if (mpend[i]) begin
          msel = i;
          break;
        end
      end
      if (mpop) void'(mq.pop_front());
      if (msel >= 0 && mq.size() < DEPTH) begin
        mev.ch  = msel;
        mev.lvl = int'(mprev[msel]);
        mev.ts  = mts;
        mq.push_back(mev);
        mpend[msel] = 1'b0;
      end
      if (mstate == M_CAP) begin
        for (int i = 0; i < NUM_CH; i++) begin
          if (sig_i[i] != mprev[i]) begin
            if (mpend[i]) begin
              movf = 1'b1;
              if (mdrop < 255) mdrop++;
            end
            mpend[i] = 1'b1;
          end
        end
      end
      case (mstate)
        M_IDLE: if (enable) mstate = M_CAP;
        M_CAP:  if (!enable) mstate = many ? M_FLSH : M_IDLE;
        default: begin
          if (enable) mstate = M_CAP;
          else if (!many) mstate = M_IDLE;
        end
      endcase
      mprev = sig_i;
      mts   = (mts + 1) % (1 << TS_W);
    end
  end

  initial begin : compare
    forever begin
      @(posedge clk);
      #1;
      chk("cmp_valid", evt_valid, mq.size() > 0);
      if (mq.size() > 0) begin
        chk("cmp_ch", evt_ch, mq[0].ch);
        chk("cmp_level", evt_level, mq[0].lvl);
        chk("cmp_ts", evt_ts, ts_exp(mq[0].ts));
      end else begin
        chk("cmp_idle_ch", evt_ch, 0);
        chk("cmp_idle_ts", evt_ts, 0);
      end
      chk("cmp_overflow", overflow, movf);
      chk("cmp_drop_cnt", drop_cnt, mdrop);
    end
  end

  task automatic drain(input string name, input int exp_n);
    int n;
    n = 0;
    evt_ready = 1'b1;
    for (int c = 0; c < 40; c++) begin
      if (evt_valid) n++;
      @(negedge clk);
    end
    chk(name, n, exp_n);
    chk({name, "_empty"}, evt_valid, 0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, actual=running required=done");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int n;
    int exp_ch [3];
    exp_ch = '{0, 5, 19};

    repeat (3) @(negedge clk);
    chk("rst_valid", evt_valid, 0);
    chk("rst_ch", evt_ch, 0);
    chk("rst_ts", evt_ts, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_drop_cnt", drop_cnt, 0);

    // Single event: change seen at edge 10, written at edge 11.
    rst_n  = 1'b1;
    enable = 1'b1;
    repeat (10) @(negedge clk);
    sig_i[3] = 1'b1;
    @(negedge clk);
    chk("single_latency", evt_valid, 0);
    @(negedge clk);
    chk("single_valid", evt_valid, 1);
    chk("single_ch", evt_ch, 3);
    chk("single_level", evt_level, 1);
    chk("single_ts", evt_ts, ts_exp(11));
    evt_ready = 1'b1;
    @(negedge clk);
    chk("single_popped", evt_valid, 0);

    // Simultaneous changes on 0, 5, 19: seen at edge 13, pushed at 14..16.
    sig_i[0]  = 1'b1;
    sig_i[5]  = 1'b1;
    sig_i[19] = 1'b1;
    @(negedge clk);
    chk("multi_latency", evt_valid, 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("multi_ch", evt_ch, exp_ch[k]);
      chk("multi_level", evt_level, 1);
      chk("multi_ts", evt_ts, ts_exp(14 + k));
    end
    @(negedge clk);
    chk("multi_done", evt_valid, 0);

    // FIFO full: 20 toggles, 16 queued, 4 held pending without loss.
    evt_ready = 1'b0;
    sig_i = ~sig_i;
    repeat (20) @(negedge clk);
    chk("full_valid", evt_valid, 1);
    chk("full_no_overflow", overflow, 0);
    evt_ready = 1'b1;
    n = 0;
    for (int c = 0; c < 40; c++) begin
      if (evt_valid) begin
        chk("full_order", evt_ch, n);
        n++;
      end
      @(negedge clk);
    end
    chk("full_count", n, 20);
    chk("full_drained", evt_valid, 0);

    // Drops: FIFO full, ch2 goes pending, then two more toggles are lost.
    evt_ready = 1'b0;
    sig_i = ~sig_i;
    repeat (20) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      sig_i[2] = ~sig_i[2];
      @(negedge clk);
    end
    chk("drop_overflow", overflow, 1);
    chk("drop_cnt_2", drop_cnt, 2);
    for (int k = 0; k < 300; k++) begin
      sig_i[2] = ~sig_i[2];
      @(negedge clk);
    end
    chk("drop_cnt_sat", drop_cnt, 255);
    drain("drop_drain", 21);
    chk("drop_sticky", overflow, 1);

    // Flush: enable falls with 3 pending; later toggles are ignored.
    evt_ready = 1'b0;
    sig_i[18:0] = ~sig_i[18:0];
    repeat (20) @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    sig_i[0]  = ~sig_i[0];
    sig_i[19] = ~sig_i[19];
    repeat (3) @(negedge clk);
    drain("flush_drain", 19);
    sig_i[7] = ~sig_i[7];
    repeat (5) @(negedge clk);
    chk("idle_no_event", evt_valid, 0);

    // Reset mid-stream with 5 events queued.
    enable = 1'b1;
    evt_ready = 1'b0;
    @(negedge clk);
    sig_i[4:0] = ~sig_i[4:0];
    repeat (8) @(negedge clk);
    chk("pre_reset_valid", evt_valid, 1);
    rst_n = 1'b0;
    sig_i = '1;
    #1;
    chk("reset_valid", evt_valid, 0);
    chk("reset_overflow", overflow, 0);
    chk("reset_drop_cnt", drop_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    evt_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("post_reset_quiet", evt_valid, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
